// File: rtl/aes_inv_key_schedule.sv
// ---------------------------------------------------------------------------
// aes_inv_key_schedule
//
// Iterative reverse AES-128 key schedule for the decryption datapath. It is
// loaded with the final round key (round 10). It then regenerates round keys
// 10, 9, ..., 0, one per accepted transfer. The only storage is the current
// 128-bit round key.
// Byte ordering is [0:127] big-endian: byte 0 is bits [0:7].
//
// Optional feature (macro AES_EQ_INV_KEY_EN):
//   defined   - rounds 1..9 are output as InvMixColumns(key), which gives the
//               round keys of the equivalent inverse cipher. Rounds 10 and 0
//               are output raw. The key register always holds raw keys.
//   undefined - rk_data is the raw key register for every round.
//
// Ports:
//   clk       clock
//   rst       asynchronous active-high reset
//   in_valid  last_key is valid
//   in_ready  block can accept a new last_key (idle)
//   last_key  round-10 key (words w40..w43)
//   rk_valid  rk_data is valid
//   rk_ready  consumer accepts rk_data
//   rk_data   current round key
//   rk_round  round index of rk_data (10 down to 0)
//   rk_last   high together with round 0
// ---------------------------------------------------------------------------
module aes_inv_key_schedule #(
    parameter int NR      = 10,
    parameter int ROUND_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [0:127]       last_key,
    output logic               rk_valid,
    input  logic               rk_ready,
    output logic [0:127]       rk_data,
    output logic [ROUND_W-1:0] rk_round,
    output logic               rk_last
);

    generate
        if (NR != 10 || ROUND_W < 4) begin : g_bad_cfg
            $error("aes_inv_key_schedule supports only NR=10 (AES-128) with ROUND_W>=4");
        end
    endgenerate

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q, state_d;
    logic [0:127]         key_q, key_d;
    logic [ROUND_W-1:0]   round_q, round_d;
    logic [0:127]         prev_key;
    logic [0:31]          k0, k1, k2, k3, p0, p1, p2, p3;

    function automatic logic [0:31] sub_word(input logic [0:31] w);
        return {SBOX[w[0:7]], SBOX[w[8:15]], SBOX[w[16:23]], SBOX[w[24:31]]};
    endfunction

    // rcon of the round whose key is currently held; round r's key was built
    // with rcon[r], so stepping back from round r undoes that same constant.
    function automatic logic [7:0] rcon(input logic [ROUND_W-1:0] r);
        case (int'(r))
            1:       return 8'h01;
            2:       return 8'h02;
            3:       return 8'h04;
            4:       return 8'h08;
            5:       return 8'h10;
            6:       return 8'h20;
            7:       return 8'h40;
            8:       return 8'h80;
            9:       return 8'h1b;
            10:      return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One combinational backward step. p3 is recovered first because the
    // forward schedule built w[i] from w[i-1] (i.e. p3 feeds SubWord/RotWord).
    assign k0 = key_q[0:31];
    assign k1 = key_q[32:63];
    assign k2 = key_q[64:95];
    assign k3 = key_q[96:127];
    assign p3 = k3 ^ k2;
    assign p2 = k2 ^ k1;
    assign p1 = k1 ^ k0;
    assign p0 = k0 ^ sub_word({p3[8:31], p3[0:7]}) ^ {rcon(round_q), 24'h000000};
    assign prev_key = {p0, p1, p2, p3};

    // NOTE: every sequential register here takes <= so all of them update
    // from the same pre-edge values. Registers get their reset values
    // through the async reset branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
        end
    end

    // NOTE: all outputs of this block are given defaults first so that
    // every path assigns them and no latch is inferred.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    key_d   = last_key;
                    round_d = ROUND_W'(NR);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (rk_ready) begin
                    if (round_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        key_d   = prev_key;
                        round_d = round_q - ROUND_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready = (state_q == IDLE);
    assign rk_valid = (state_q == RUN);
    assign rk_round = round_q;
    assign rk_last  = (state_q == RUN) && (round_q == '0);

`ifdef AES_EQ_INV_KEY_EN
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns of one column, via xtime multiples:
    // 09 = 8+1, 0b = 8+2+1, 0d = 8+4+1, 0e = 8+4+2.
    function automatic logic [0:31] inv_mix_col(input logic [0:31] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[8*i +: 8];
            m9[i] = xt(xt(xt(a[i]))) ^ a[i];
            mb[i] = xt(xt(xt(a[i]))) ^ xt(a[i]) ^ a[i];
            md[i] = xt(xt(xt(a[i]))) ^ xt(xt(a[i])) ^ a[i];
            me[i] = xt(xt(xt(a[i]))) ^ xt(xt(a[i])) ^ xt(a[i]);
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    always_comb begin
        rk_data = key_q;
        if (round_q >= ROUND_W'(1) && round_q <= ROUND_W'(9)) begin
            rk_data = {inv_mix_col(k0), inv_mix_col(k1), inv_mix_col(k2), inv_mix_col(k3)};
        end
    end
`else
    assign rk_data = key_q;
`endif

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
module tb_aes_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] last_key;
    logic         rk_valid;
    logic         rk_ready;
    logic [0:127] rk_data;
    logic [3:0]   rk_round;
    logic         rk_last;

    aes_inv_key_schedule #(.NR(10), .ROUND_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .last_key (last_key),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_data  (rk_data),
        .rk_round (rk_round),
        .rk_last  (rk_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   round;
        logic [0:127] data;
        logic         last;
        bit           chk;   // data known for this entry
    } vec_t;

    localparam logic [0:127] A1_KEY   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [0:127] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    vec_t a1_tab [11];
    vec_t zr_tab [11];
    vec_t sb [$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] p;
        a = a_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [0:127] ref_inv_mix(input logic [0:127] raw);
        logic [7:0]   m [4];
        logic [7:0]   acc;
        logic [0:127] res;
        m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(raw[32*c + 8*k +: 8], m[(k - j + 4) % 4]);
                res[32*c + 8*j +: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic logic [0:127] exp_data(input int r, input logic [0:127] raw);
`ifdef AES_EQ_INV_KEY_EN
        if (r >= 1 && r <= 9) return ref_inv_mix(raw);
`endif
        return raw;
    endfunction

    task automatic push_seq(input bit zero_key);
        vec_t e;
        for (int i = 0; i < 11; i++) begin
            e = zero_key ? zr_tab[i] : a1_tab[i];
            e.data = exp_data(int'(e.round), e.data);
            sb.push_back(e);
        end
    endtask

    // Called just after a negedge; returns just after the negedge that follows
    // the last transfer. Outputs are sampled 1 ns after the negedge.
    task automatic drain(input bit rnd, input int max_xfers, output int cyc);
        int           xf;
        bit           hold;
        logic [0:127] hd;
        logic [3:0]   hr;
        vec_t         e;
        cyc  = 0;
        xf   = 0;
        hold = 1'b0;
        hd   = '0;
        hr   = '0;
        while (xf < max_xfers && sb.size() > 0) begin
            if (cyc >= 400) begin
                check("drain_timeout", 1'b0, 1'b1);
                sb.delete();
                break;
            end
            rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (hold) begin
                check("hold_data", rk_data, hd);
                check("hold_round", rk_round, hr);
            end
            check("busy_in_ready", in_ready, 1'b0);
            check("run_rk_valid", rk_valid, 1'b1);
            hold = 1'b0;
            if (rk_valid && rk_ready) begin
                e = sb.pop_front();
                check($sformatf("round_idx_r%0d", e.round), rk_round, e.round);
                if (e.chk) check($sformatf("rk_data_r%0d", e.round), rk_data, e.data);
                check($sformatf("rk_last_r%0d", e.round), rk_last, e.last);
                xf++;
            end else if (rk_valid) begin
                hold = 1'b1;
                hd   = rk_data;
                hr   = rk_round;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    // Presents a key for one cycle and checks the one-cycle load latency.
    task automatic load(input logic [0:127] key, input bit zero_key);
        in_valid = 1'b1;
        last_key = key;
        #1;
        check("load_in_ready", in_ready, 1'b1);
        push_seq(zero_key);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("load_latency_valid", rk_valid, 1'b1);
        check("load_latency_round", rk_round, 4'd10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        // FIPS-197 A.1 raw round keys, listed in decryption order.
        a1_tab[0]  = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0, 1'b1};
        a1_tab[1]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e, 1'b0, 1'b1};
        a1_tab[2]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f, 1'b0, 1'b1};
        a1_tab[3]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f, 1'b0, 1'b1};
        a1_tab[4]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd, 1'b0, 1'b1};
        a1_tab[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc, 1'b0, 1'b1};
        a1_tab[6]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00, 1'b0, 1'b1};
        a1_tab[7]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b, 1'b0, 1'b1};
        a1_tab[8]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f, 1'b0, 1'b1};
        a1_tab[9]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b0, 1'b1};
        a1_tab[10] = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, 1'b1};

        // All-zero cipher key: only rounds 10, 1 and 0 carry a data check.
        for (int i = 0; i < 11; i++) zr_tab[i] = '{4'(10 - i), '0, (i == 10), 1'b0};
        zr_tab[0]  = '{4'd10, ZERO_R10, 1'b0, 1'b1};
        zr_tab[9]  = '{4'd1,  128'h62636363626363636263636362636363, 1'b0, 1'b1};
        zr_tab[10] = '{4'd0,  128'h0, 1'b1, 1'b1};

        rst      = 1'b1;
        in_valid = 1'b0;
        last_key = '0;
        rk_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_rk_valid", rk_valid, 1'b0);
        check("reset_rk_data", rk_data, 128'h0);
        check("reset_rk_round", rk_round, 4'd0);
        check("reset_rk_last", rk_last, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Idle sanity: rk_ready activity without a load changes nothing.
        for (int i = 0; i < 6; i++) begin
            rk_ready = 1'(i % 2);
            #1;
            check("idle_rk_valid", rk_valid, 1'b0);
            check("idle_in_ready", in_ready, 1'b1);
            check("idle_rk_round", rk_round, 4'd0);
            @(negedge clk);
        end

        // A.1 with rk_ready held high: 11 keys on 11 consecutive cycles.
        load(A1_KEY, 1'b0);
        drain(1'b0, 11, cyc);
        check("a1_consecutive_cycles", 32'(cyc), 32'd11);
        #1;
        check("a1_done_idle", in_ready, 1'b1);
        check("a1_done_valid", rk_valid, 1'b0);

        // Same vector under pseudo-random backpressure.
        load(A1_KEY, 1'b0);
        drain(1'b1, 11, cyc);
        check("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Back-to-back: in_valid held high through the first sequence.
        in_valid = 1'b1;
        last_key = A1_KEY;
        #1;
        check("b2b_first_ready", in_ready, 1'b1);
        push_seq(1'b0);
        @(negedge clk);
        last_key = ZERO_R10;
        drain(1'b0, 11, cyc);
        #1;
        check("b2b_gap_in_ready", in_ready, 1'b1);
        check("b2b_gap_rk_valid", rk_valid, 1'b0);
        push_seq(1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("b2b_second_valid", rk_valid, 1'b1);
        check("b2b_second_round", rk_round, 4'd10);
        drain(1'b0, 11, cyc);
        check("b2b_sb_empty", 32'(sb.size()), 32'd0);

        // Reset after round 6 has been transferred.
        load(A1_KEY, 1'b0);
        drain(1'b0, 5, cyc);
        #1;
        check("pre_reset_round", rk_round, 4'd5);
        rst = 1'b1;
        #1;
        check("midrst_rk_valid", rk_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_rk_round", rk_round, 4'd0);
        check("midrst_rk_last", rk_last, 1'b0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        load(A1_KEY, 1'b0);
        drain(1'b0, 11, cyc);
        check("restart_cycles", 32'(cyc), 32'd11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
